mem_arbiter: RTL

Shares the single-port 4 x 8-bit register memory between NUM_REQ requesters. It sits between the requester agents and the memory's addr/wr_en/rd_en/wdata/rdata port. It grants one access at a time by round-robin, drives the memory command for exactly one cycle, and routes read data back to the granted requester with a registered valid pulse.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_rr_pick.sv | 49 ++++
 rtl/mem_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package mem_arb_pkg;

    localparam int MAX_REQ    = 4;
    localparam int PTR_W      = 2;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } arb_state_t;

    // Requester index reached by stepping off positions past ptr, wrapping at n.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] ptr,
                                                  input int off, input int n);
        return PTR_W'((int'(ptr) + off) % n);
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational winner picker: round-robin from ptr+1, or lowest index first
// when MEM_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               found
);

    logic [MAX_REQ-1:0] req_ext;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
        win_idx = '0;
        found   = 1'b0;
        win     = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_ext[i]) begin
                win_idx = PTR_W'(i);
                found   = 1'b1;
            end
        end
`else
        // Scan farthest-first so the candidate nearest ptr+1 overwrites the rest.
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_ext[next_idx(ptr, i, NUM_REQ)]) begin
                win_idx = next_idx(ptr, i, NUM_REQ);
                found   = 1'b1;
            end
        end
`endif
        for (int j = 0; j < NUM_REQ; j++) begin
            win[j] = found && (win_idx == PTR_W'(j));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one access at a time, registered command and read return.
// Build option: MEM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_wr_en,
    output logic                        mem_rd_en,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    arb_state_t         state;
    logic [NUM_REQ-1:0] win_q;
    logic [NUM_REQ-1:0] pick_win;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic [PTR_W-1:0]   ptr;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_idx;
    assign ptr        = '0;
    assign unused_idx = ^pick_idx;
`endif

    mem_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            win_q     <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr       <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            gnt       <= '0;
            rvalid    <= '0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= ISSUE;
                        win_q     <= pick_win;
                        gnt       <= pick_win;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_wr_en <= sel_we;
                        mem_rd_en <= !sel_we;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        ptr       <= pick_idx;
`endif
                    end
                end
                // The registered write enable is the latched direction of this access.
                ISSUE:  state <= mem_wr_en ? IDLE : RDWAIT;
                RDWAIT: begin
                    rdata  <= mem_rdata;
                    rvalid <= win_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
